// File: rtl/axi_mwrite_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi_mwrite_pkg
//  Description : Shared definitions for the byte-granular AXI4 write master.
//                Holds the controller state encodings and the AXI constants
//                used by the top level and the strobe generator.
//  Revision    : 1.0 - initial release
// ============================================================================
package axi_mwrite_pkg;

    // Controller states, two bits wide.
    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_ADDR = 2'd1;
    localparam state_t ST_DATA = 2'd2;
    localparam state_t ST_RESP = 2'd3;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    // A burst may never cross this address boundary.
    localparam int unsigned PAGE_BYTES = 4096;

endpackage
`default_nettype wire

// File: rtl/axi_wstrb_gen.sv
`default_nettype none
// ============================================================================
//  Module      : axi_wstrb_gen
//  Description : Combinational write-strobe generator. Trims the first beat
//                of a transfer below its start lane and the last beat above
//                its end lane; a single-beat transfer gets both trims and
//                every other beat is fully enabled.
//  Ports       : i_start_lane - byte lane of the first byte of the transfer
//                i_end_lane   - byte lane of the last byte of the transfer
//                i_first      - current beat is the first of the transfer
//                i_last       - current beat is the last of the transfer
//                o_w_strb     - byte enables for the current beat
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_wstrb_gen
    import axi_mwrite_pkg::*;
#(
    parameter  int D_POWER = 3,
    localparam int B_WIDTH = 1 << D_POWER
) (
    input  logic [D_POWER-1:0] i_start_lane,
    input  logic [D_POWER-1:0] i_end_lane,
    input  logic               i_first,
    input  logic               i_last,
    output logic [B_WIDTH-1:0] o_w_strb
);

    localparam logic [B_WIDTH-1:0] c_ONES     = '1;
    localparam logic [D_POWER-1:0] c_TOP_LANE = '1;

    logic [B_WIDTH-1:0] w_lo_mask;
    logic [B_WIDTH-1:0] w_hi_mask;

    // Lanes at or above the start lane.
    assign w_lo_mask = c_ONES << i_start_lane;
    // Lanes at or below the end lane.
    assign w_hi_mask = c_ONES >> (c_TOP_LANE - i_end_lane);

    assign o_w_strb = (i_first ? w_lo_mask : c_ONES) & (i_last ? w_hi_mask : c_ONES);

endmodule
`default_nettype wire

// File: rtl/axi_mwrite_unaligned.sv
`default_nettype none
// ============================================================================
//  Module      : axi_mwrite_unaligned
//  Description : AXI4 write-channel master for byte-granular transfers. Takes
//                a byte start address and byte count, splits the transfer into
//                INCR bursts limited by the maximum burst length and by 4 KB
//                pages, gates the lane-aligned user stream onto W with per-beat
//                strobes and collects the B responses (sticky error flag).
//  Ports       : sys_clock, async_reset (active low, asynchronous)
//                i_addr/i_len/i_req      - request, accepted in IDLE only
//                or_busy/o_done/o_err    - request status
//                i_data/i_valid/o_ready  - user write stream
//                o_aw_*/i_aw_ready       - AXI write address channel
//                o_w_*/i_w_ready         - AXI write data channel
//                i_b_resp/i_b_valid/o_b_ready - AXI write response channel
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_mwrite_unaligned
    import axi_mwrite_pkg::*;
#(
    parameter  int D_POWER       = 3,
    parameter  int MAX_BURST_LOG = 8,
    localparam int D_WIDTH       = 8 * (1 << D_POWER),
    localparam int B_WIDTH       = 1 << D_POWER
) (
    input  logic               sys_clock,
    input  logic               async_reset,
    input  logic [31:0]        i_addr,
    input  logic [31:0]        i_len,
    input  logic               i_req,
    output logic               or_busy,
    output logic               o_done,
    output logic               o_err,
    input  logic [D_WIDTH-1:0] i_data,
    input  logic               i_valid,
    output logic               o_ready,
    output logic [31:0]        o_aw_addr,
    output logic [7:0]         o_aw_len,
    output logic [2:0]         o_aw_size,
    output logic [1:0]         o_aw_burst,
    output logic               o_aw_valid,
    input  logic               i_aw_ready,
    output logic [D_WIDTH-1:0] o_w_data,
    output logic [B_WIDTH-1:0] o_w_strb,
    output logic               o_w_last,
    output logic               o_w_valid,
    input  logic               i_w_ready,
    input  logic [1:0]         i_b_resp,
    input  logic               i_b_valid,
    output logic               o_b_ready
);

    localparam logic [31:0] c_PAGE_BEATS = 32'(PAGE_BYTES >> D_POWER);
    localparam logic [31:0] c_MAX_BEATS  = 32'd1 << MAX_BURST_LOG;

    // Beats in the next burst: limited by what is left, the burst cap and
    // the distance to the next page boundary.
    function automatic logic [31:0] f_burst_beats(input logic [31:0] idx,
                                                  input logic [31:0] rem);
        logic [31:0] w_to_page;
        logic [31:0] w_lim;
        w_to_page = c_PAGE_BEATS - (idx & (c_PAGE_BEATS - 32'd1));
        w_lim     = (w_to_page < c_MAX_BEATS) ? w_to_page : c_MAX_BEATS;
        return (rem < w_lim) ? rem : w_lim;
    endfunction

    state_t              r_state;
    state_t              w_state_nxt;
    logic [31:0]         r_beat_idx;     // beat index of the next burst
    logic [31:0]         r_remaining;    // beats not yet assigned to a burst
    logic [D_POWER-1:0]  r_start_lane;
    logic [D_POWER-1:0]  r_end_lane;
    logic                r_first;        // next W beat is the first of the transfer
    logic [7:0]          r_beat_cnt;     // beats left in the current burst, minus 1
    logic [31:0]         r_aw_addr;
    logic [7:0]          r_aw_len;
    logic                r_aw_valid;
    logic                r_b_ready;
    logic                r_busy;
    logic                r_done;
    logic                r_err;

    logic [31:0]         w_end;
    logic [31:0]         w_req_beat;
    logic [31:0]         w_req_total;
    logic                w_accept;
    logic                w_aw_hs;
    logic                w_w_hs;
    logic                w_b_hs;
    logic                w_burst_last;
    logic                w_xfer_last;
    logic [31:0]         w_sel_idx;
    logic [31:0]         w_sel_rem;
    logic [31:0]         w_burst;

    assign w_end        = i_addr + i_len - 32'd1;
    assign w_req_beat   = i_addr >> D_POWER;
    assign w_req_total  = (w_end >> D_POWER) - w_req_beat + 32'd1;
    // While r_busy is high in IDLE a zero-length request is being closed out.
    assign w_accept     = (r_state == ST_IDLE) && i_req && !r_busy;
    assign w_aw_hs      = r_aw_valid && i_aw_ready;
    assign w_w_hs       = (r_state == ST_DATA) && i_valid && i_w_ready;
    assign w_b_hs       = i_b_valid && r_b_ready;
    assign w_burst_last = (r_beat_cnt == 8'd0);
    // r_remaining is already reduced by the current burst, so zero here
    // means this burst finishes the transfer.
    assign w_xfer_last  = w_burst_last && (r_remaining == 32'd0);

    // A burst is sized either from the fresh request or from the running
    // position after a response.
    assign w_sel_idx = (r_state == ST_IDLE) ? w_req_beat  : r_beat_idx;
    assign w_sel_rem = (r_state == ST_IDLE) ? w_req_total : r_remaining;
    assign w_burst   = f_burst_beats(w_sel_idx, w_sel_rem);

    always_ff @(posedge sys_clock or negedge async_reset) begin
        if (!async_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept && (i_len != 32'd0)) w_state_nxt = ST_ADDR;
            ST_ADDR: if (w_aw_hs) w_state_nxt = ST_DATA;
            ST_DATA: if (w_w_hs && w_burst_last) w_state_nxt = ST_RESP;
            ST_RESP: if (w_b_hs) w_state_nxt = (r_remaining == 32'd0) ? ST_IDLE : ST_ADDR;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clock or negedge async_reset) begin
        if (!async_reset) begin
            r_beat_idx   <= '0;
            r_remaining  <= '0;
            r_start_lane <= '0;
            r_end_lane   <= '0;
            r_first      <= 1'b0;
            r_beat_cnt   <= '0;
            r_aw_addr    <= '0;
            r_aw_len     <= '0;
            r_aw_valid   <= 1'b0;
            r_b_ready    <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (r_busy) begin
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                    end else if (i_req) begin
                        r_busy       <= 1'b1;
                        r_err        <= 1'b0;
                        r_first      <= 1'b1;
                        r_start_lane <= i_addr[D_POWER-1:0];
                        r_end_lane   <= w_end[D_POWER-1:0];
                        if (i_len != 32'd0) begin
                            r_aw_addr   <= w_sel_idx << D_POWER;
                            r_aw_len    <= 8'(w_burst - 32'd1);
                            r_aw_valid  <= 1'b1;
                            r_beat_idx  <= w_sel_idx + w_burst;
                            r_remaining <= w_sel_rem - w_burst;
                        end
                    end
                end
                ST_ADDR: begin
                    if (w_aw_hs) begin
                        r_aw_valid <= 1'b0;
                        r_beat_cnt <= r_aw_len;
                    end
                end
                ST_DATA: begin
                    if (w_w_hs) begin
                        r_first <= 1'b0;
                        if (w_burst_last) begin
                            r_b_ready <= 1'b1;
                        end else begin
                            r_beat_cnt <= r_beat_cnt - 8'd1;
                        end
                    end
                end
                ST_RESP: begin
                    if (w_b_hs) begin
                        r_b_ready <= 1'b0;
                        if (i_b_resp != AXI_RESP_OKAY) begin
                            r_err <= 1'b1;
                        end
                        if (r_remaining == 32'd0) begin
                            r_busy <= 1'b0;
                            r_done <= 1'b1;
                        end else begin
                            r_aw_addr   <= w_sel_idx << D_POWER;
                            r_aw_len    <= 8'(w_burst - 32'd1);
                            r_aw_valid  <= 1'b1;
                            r_beat_idx  <= w_sel_idx + w_burst;
                            r_remaining <= w_sel_rem - w_burst;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    axi_wstrb_gen #(
        .D_POWER      (D_POWER)
    ) u_wstrb_gen (
        .i_start_lane (r_start_lane),
        .i_end_lane   (r_end_lane),
        .i_first      (r_first),
        .i_last       (w_xfer_last),
        .o_w_strb     (o_w_strb)
    );

    assign or_busy    = r_busy;
    assign o_done     = r_done;
    assign o_err      = r_err;
    assign o_aw_addr  = r_aw_addr;
    assign o_aw_len   = r_aw_len;
    assign o_aw_size  = 3'(D_POWER);
    assign o_aw_burst = AXI_BURST_INCR;
    assign o_aw_valid = r_aw_valid;
    assign o_w_data   = i_data;
    assign o_w_last   = (r_state == ST_DATA) && w_burst_last;
    assign o_w_valid  = (r_state == ST_DATA) && i_valid;
    assign o_ready    = (r_state == ST_DATA) && i_w_ready;
    assign o_b_ready  = r_b_ready;

endmodule
`default_nettype wire

// File: tb/tb_axi_mwrite_unaligned.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_mwrite_unaligned
//  Description : Self-checking bench for axi_mwrite_unaligned (64-bit bus,
//                256-beat burst cap). A reference model expands each request
//                into expected AW and W entries; a monitor pops and compares
//                them on every handshake and acts as AXI slave and user source.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_mwrite_unaligned;

    localparam int D_POWER       = 3;
    localparam int MAX_BURST_LOG = 8;
    localparam int D_WIDTH       = 64;
    localparam int B_WIDTH       = 8;

    logic               sys_clock   = 1'b0;
    logic               async_reset = 1'b0;
    logic [31:0]        i_addr      = '0;
    logic [31:0]        i_len       = '0;
    logic               i_req       = 1'b0;
    logic               or_busy;
    logic               o_done;
    logic               o_err;
    logic [D_WIDTH-1:0] i_data      = '0;
    logic               i_valid     = 1'b0;
    logic               o_ready;
    logic [31:0]        o_aw_addr;
    logic [7:0]         o_aw_len;
    logic [2:0]         o_aw_size;
    logic [1:0]         o_aw_burst;
    logic               o_aw_valid;
    logic               i_aw_ready  = 1'b1;
    logic [D_WIDTH-1:0] o_w_data;
    logic [B_WIDTH-1:0] o_w_strb;
    logic               o_w_last;
    logic               o_w_valid;
    logic               i_w_ready   = 1'b1;
    logic [1:0]         i_b_resp    = 2'b00;
    logic               i_b_valid   = 1'b0;
    logic               o_b_ready;

    always #5 sys_clock = ~sys_clock;

    axi_mwrite_unaligned #(
        .D_POWER       (D_POWER),
        .MAX_BURST_LOG (MAX_BURST_LOG)
    ) dut (
        .sys_clock  (sys_clock),
        .async_reset(async_reset),
        .i_addr     (i_addr),
        .i_len      (i_len),
        .i_req      (i_req),
        .or_busy    (or_busy),
        .o_done     (o_done),
        .o_err      (o_err),
        .i_data     (i_data),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .o_aw_addr  (o_aw_addr),
        .o_aw_len   (o_aw_len),
        .o_aw_size  (o_aw_size),
        .o_aw_burst (o_aw_burst),
        .o_aw_valid (o_aw_valid),
        .i_aw_ready (i_aw_ready),
        .o_w_data   (o_w_data),
        .o_w_strb   (o_w_strb),
        .o_w_last   (o_w_last),
        .o_w_valid  (o_w_valid),
        .i_w_ready  (i_w_ready),
        .i_b_resp   (i_b_resp),
        .i_b_valid  (i_b_valid),
        .o_b_ready  (o_b_ready)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  len;
    } aw_exp_t;

    typedef struct packed {
        logic [7:0] strb;
        logic       last;
    } w_exp_t;

    aw_exp_t q_aw[$];
    w_exp_t  q_w[$];

    int   n_cmp      = 0;
    int   n_err      = 0;
    logic stall_mode = 1'b0;
    int   err_idx    = -1;
    int   b_seen     = 0;
    int   req_bursts = 0;
    int   w_seen     = 0;
    logic b_due      = 1'b0;
    logic done_due   = 1'b0;

    task automatic t_check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Expand a request byte-by-byte into expected beats and bursts.
    task automatic t_model(input logic [31:0] addr, input logic [31:0] len, output int nb);
        logic [63:0] lo, hi, first_b, last_b, start_b;
        int          n;
        aw_exp_t     ea;
        w_exp_t      ew;
        logic        endb;
        nb      = 0;
        n       = 0;
        lo      = 64'(addr);
        hi      = lo + 64'(len) - 64'd1;
        first_b = lo >> 3;
        last_b  = hi >> 3;
        start_b = first_b;
        for (logic [63:0] b = first_b; b <= last_b; b++) begin
            if (n == 0) start_b = b;
            for (int l = 0; l < 8; l++) begin
                logic [63:0] byte_a;
                byte_a     = b * 64'd8 + 64'(l);
                ew.strb[l] = (byte_a >= lo) && (byte_a <= hi);
            end
            n++;
            endb    = (b == last_b) || (n == 256) || (((b + 64'd1) % 64'd512) == 64'd0);
            ew.last = endb;
            q_w.push_back(ew);
            if (endb) begin
                ea.addr = 32'(start_b * 64'd8);
                ea.len  = 8'(n - 1);
                q_aw.push_back(ea);
                nb++;
                n = 0;
            end
        end
    endtask

    // Monitor, AXI slave and user data source.
    always begin : p_mon
        logic        aw_hs, w_hs, b_hs;
        logic        aw_pend, w_pend;
        logic [31:0] p_aw_addr;
        logic [7:0]  p_aw_len;
        logic [7:0]  p_strb;
        logic        p_last;
        logic [63:0] p_data;
        aw_exp_t     ea;
        w_exp_t      ew;
        aw_pend = 1'b0;
        w_pend  = 1'b0;
        forever begin
            @(negedge sys_clock);
            aw_hs = o_aw_valid && i_aw_ready;
            w_hs  = o_w_valid && i_w_ready;
            b_hs  = i_b_valid && o_b_ready;
            if (done_due) begin
                t_check("done_after_b", o_done, 1);
                t_check("busy_fall", or_busy, 0);
                done_due = 1'b0;
            end
            if (aw_pend) begin
                t_check("aw_valid_hold", o_aw_valid, 1);
                t_check("aw_addr_hold", o_aw_addr, p_aw_addr);
                t_check("aw_len_hold", o_aw_len, p_aw_len);
            end
            if (w_pend) begin
                t_check("w_valid_hold", o_w_valid, 1);
                t_check("w_strb_hold", o_w_strb, p_strb);
                t_check("w_last_hold", o_w_last, p_last);
                t_check("w_data_hold", o_w_data, p_data);
            end
            aw_pend   = o_aw_valid && !i_aw_ready;
            p_aw_addr = o_aw_addr;
            p_aw_len  = o_aw_len;
            w_pend    = o_w_valid && !i_w_ready;
            p_strb    = o_w_strb;
            p_last    = o_w_last;
            p_data    = o_w_data;
            if (aw_hs) begin
                if (q_aw.size() == 0) begin
                    t_check("aw_unexpected", 1, 0);
                end else begin
                    ea = q_aw.pop_front();
                    t_check("aw_addr", o_aw_addr, ea.addr);
                    t_check("aw_len", o_aw_len, ea.len);
                    t_check("aw_size", o_aw_size, 3);
                    t_check("aw_burst", o_aw_burst, 1);
                end
            end
            if (w_hs) begin
                w_seen++;
                t_check("user_ready", o_ready, 1);
                t_check("w_data", o_w_data, i_data);
                if (q_w.size() == 0) begin
                    t_check("w_unexpected", 1, 0);
                end else begin
                    ew = q_w.pop_front();
                    t_check("w_strb", o_w_strb, ew.strb);
                    t_check("w_last", o_w_last, ew.last);
                end
                if (o_w_last) b_due = 1'b1;
            end
            if (b_hs) begin
                b_seen++;
                if (b_seen == req_bursts) done_due = 1'b1;
            end
            @(posedge sys_clock);
            #1;
            i_aw_ready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            i_w_ready  = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            if (w_hs || !i_valid) begin
                i_valid = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
                i_data  = {$urandom(), $urandom()};
            end
            if (b_hs) i_b_valid = 1'b0;
            if (b_due) begin
                i_b_valid = 1'b1;
                i_b_resp  = (b_seen == err_idx) ? 2'b10 : 2'b00;
                b_due     = 1'b0;
            end
        end
    end

    task automatic t_issue(input logic [31:0] addr, input logic [31:0] len);
        @(posedge sys_clock);
        #1;
        i_req  = 1'b1;
        i_addr = addr;
        i_len  = len;
        @(posedge sys_clock);
        #1;
        i_req  = 1'b0;
    endtask

    task automatic t_wait_done(input int budget);
        logic got;
        got = 1'b0;
        for (int c = 0; c < budget && !got; c++) begin
            @(negedge sys_clock);
            if (o_done) got = 1'b1;
        end
        if (!got) t_check("done_timeout", 0, 1);
    endtask

    task automatic t_run(input logic [31:0] addr, input logic [31:0] len,
                         input int eidx, input logic stalls);
        int nb;
        t_model(addr, len, nb);
        stall_mode = stalls;
        err_idx    = eidx;
        b_seen     = 0;
        req_bursts = nb;
        t_issue(addr, len);
        t_wait_done(20000);
        t_check("o_err", o_err, ((eidx >= 0) && (eidx < nb)) ? 1 : 0);
        t_check("busy_at_done", or_busy, 0);
        t_check("aw_left", q_aw.size(), 0);
        t_check("w_left", q_w.size(), 0);
        stall_mode = 1'b0;
    endtask

    initial begin : p_main
        int nb;
        int w_start;
        logic got;

        repeat (3) @(posedge sys_clock);
        #1;
        t_check("rst_busy", or_busy, 0);
        t_check("rst_done", o_done, 0);
        t_check("rst_err", o_err, 0);
        t_check("rst_aw_valid", o_aw_valid, 0);
        t_check("rst_b_ready", o_b_ready, 0);
        t_check("rst_aw_addr", o_aw_addr, 0);
        t_check("rst_aw_len", o_aw_len, 0);
        @(negedge sys_clock);
        async_reset = 1'b1;

        t_run(32'h0000_1000, 32'd64, -1, 1'b0);
        t_run(32'h0000_1003, 32'd10, -1, 1'b0);
        t_run(32'h0000_1005, 32'd2,  -1, 1'b0);
        t_run(32'h0000_0FF8, 32'd16, -1, 1'b0);
        t_run(32'h0000_0000, 32'd4096, 1, 1'b1);

        // Zero-length request: no AXI traffic, error flag cleared.
        t_issue(32'h0000_3000, 32'd0);
        @(negedge sys_clock);
        t_check("noop_busy", or_busy, 1);
        t_check("noop_done_early", o_done, 0);
        t_check("err_cleared", o_err, 0);
        t_check("noop_aw_valid", o_aw_valid, 0);
        @(negedge sys_clock);
        t_check("noop_done", o_done, 1);
        t_check("noop_busy_fall", or_busy, 0);

        // Reset in the middle of a data phase.
        t_model(32'h0000_2000, 32'd256, nb);
        req_bursts = nb;
        b_seen     = 0;
        err_idx    = -1;
        w_start    = w_seen;
        t_issue(32'h0000_2000, 32'd256);
        got = 1'b0;
        for (int c = 0; c < 200 && !got; c++) begin
            @(negedge sys_clock);
            if (w_seen >= w_start + 3) got = 1'b1;
        end
        if (!got) t_check("data_phase_timeout", 0, 1);
        #2;
        async_reset = 1'b0;
        #1;
        t_check("mid_rst_busy", or_busy, 0);
        t_check("mid_rst_done", o_done, 0);
        t_check("mid_rst_err", o_err, 0);
        t_check("mid_rst_aw_valid", o_aw_valid, 0);
        t_check("mid_rst_aw_addr", o_aw_addr, 0);
        t_check("mid_rst_aw_len", o_aw_len, 0);
        t_check("mid_rst_b_ready", o_b_ready, 0);
        t_check("mid_rst_w_valid", o_w_valid, 0);
        t_check("mid_rst_ready", o_ready, 0);
        q_aw.delete();
        q_w.delete();
        @(posedge sys_clock);
        @(negedge sys_clock);
        async_reset = 1'b1;

        // A fresh request after reset shows the controller is back in IDLE.
        t_run(32'h0000_1005, 32'd2, -1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin : p_watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/axi_mwrite_unaligned.md
Name: axi_mwrite_unaligned

Overview:
AXI4 write-channel master for byte-granular transfers: arbitrary byte start address and byte length, with per-beat write strobes. Successor to the aligned writer in axi4_master/. Adds byte-level start/end, parametrised maximum burst length, 4 KB boundary splitting, an explicit INCR burst type and error reporting. User data arrives lane-aligned: byte at address A is on lane A mod B_WIDTH. The block only gates the stream and generates strobes; it does not shift data.

Parameters:
D_POWER, 3, log2 of bytes per beat (3 gives a 64-bit bus); legal 2..7.
D_WIDTH, 8*(1<<D_POWER), data bus width in bits (derived).
B_WIDTH, 1<<D_POWER, strobe width / bytes per beat (derived).
MAX_BURST_LOG, 8, log2 of the maximum beats per burst; legal 0..8.

Ports:
sys_clock  in  1  clock
async_reset  in  1  asynchronous, active-low reset
i_addr  in  32  byte start address, sampled on request acceptance
i_len  in  32  byte count, sampled on request acceptance
i_req  in  1  start request, accepted only in IDLE
or_busy  out  1  high from the cycle after acceptance until completion
o_done  out  1  one-cycle pulse when the final B response is accepted (or on the no-op path)
o_err  out  1  sticky: any B response of this request was not OKAY
i_data  in  D_WIDTH  user write data, lane-aligned
i_valid  in  1  user data valid
o_ready  out  1  user data accepted when i_valid & o_ready
o_aw_addr  out  32  burst address, aligned to B_WIDTH
o_aw_len  out  8  beats minus 1
o_aw_size  out  3  constant D_POWER
o_aw_burst  out  2  constant 2'b01 (INCR)
o_aw_valid / i_aw_ready  out/in  1  AW handshake
o_w_data  out  D_WIDTH  equal to i_data (combinational)
o_w_strb  out  B_WIDTH  byte enables
o_w_last  out  1  asserted on the last beat of the burst
o_w_valid / i_w_ready  out/in  1  W handshake
i_b_resp  in  2  write response
i_b_valid / o_b_ready  in/out  1  B handshake

Behaviour:
- Reset (async, active low): state IDLE; or_busy, o_done, o_err, o_aw_valid, o_b_ready = 0; o_aw_addr, o_aw_len = 0.
- On acceptance, compute:
  - start beat index SB = i_addr >> D_POWER
  - end byte E = i_addr + i_len - 1
  - total beats = (E >> D_POWER) - SB + 1
  - start lane = i_addr[D_POWER-1:0]; end lane = E[D_POWER-1:0]
  - clear o_err
- i_len = 0: no AXI traffic; or_busy high for one cycle, then o_done pulses; return to IDLE.
- Address arithmetic wraps modulo 2^32. Transfers that wrap past 0xFFFFFFFF are unsupported and undefined.
- States: IDLE -> ADDR -> DATA -> RESP -> (ADDR if beats remain, else IDLE).
- ADDR:
  - Burst beats = min(remaining, 1<<MAX_BURST_LOG, beats to next 4 KB boundary).
  - o_aw_addr = current beat index << D_POWER; o_aw_len = burst beats - 1.
  - o_aw_valid is held with stable payload until i_aw_ready; go to DATA on that handshake.
- DATA:
  - o_w_valid = i_valid; o_ready = i_w_ready. Both are 0 outside DATA.
  - Each beat transfers on i_valid & i_w_ready. A per-burst beat counter drives o_w_last.
  - After the last beat, raise o_b_ready and go to RESP.
- Strobes:
  - first beat of the transfer: lanes >= start lane
  - last beat of the transfer: lanes <= end lane
  - single-beat transfer: AND of the two
  - all other beats: all ones
- RESP: on i_b_valid & o_b_ready, drop o_b_ready. If i_b_resp != 2'b00, set o_err. The transfer continues after an error; no abort.
- o_done pulses in the cycle after the final B handshake, the same cycle or_busy falls.
- AW and W are serialised: no W before the AW handshake, one burst outstanding at a time.
- i_req outside IDLE is ignored.
- Reset mid-operation returns to IDLE immediately. Recovering a partially issued burst is the system's responsibility.

Decomposition:
- Package axi_mwrite_pkg: state encodings; AXI_BURST_INCR = 2'b01; AXI_RESP_OKAY = 2'b00; PAGE_BYTES = 4096.
- Sub-module axi_wstrb_gen: combinational. Inputs: start lane, end lane, first flag, last flag. Output: o_w_strb. Parametrised by D_POWER.
- Burst-size and 4 KB arithmetic stay in the top module.

Test Plan (D_POWER=3, MAX_BURST_LOG=8; slave always ready unless stated):
- addr 0x1000, len 64 -> one AW 0x1000 len 7; 8 beats strb 0xFF; w_last on beat 8; o_done; o_err 0.
- addr 0x1003, len 10 -> AW 0x1000 len 1; beat0 strb 0xF8, beat1 strb 0x1F with w_last.
- addr 0x1005, len 2 -> AW 0x1000 len 0; single beat strb 0x60, w_last 1.
- addr 0x0FF8, len 16 -> AW 0x0FF8 len 0, then AW 0x1000 len 0 (4 KB split); 2 beats strb 0xFF.
- addr 0x0, len 4096; second B response SLVERR; random i_w_ready/i_valid stalls -> AW 0x000 len 255 and AW 0x800 len 255; payload stable under stalls; o_err 1 after o_done; o_err cleared on next accepted request.
- len 0 request -> no AW/W/B activity; o_done one cycle after acceptance. Then assert async_reset mid-DATA -> all outputs at reset values immediately, state IDLE.
